// File: rtl/arm_mul_unit.sv
// arm_mul_unit: iterative radix-2 shift-add MUL/MLA/UMULL/SMULL engine with start/busy/done handshake.
// Ports:
//   i_clk        clock, all state changes on rising edge
//   i_reset_n    asynchronous active-low reset
//   i_start      request a new operation (ignored while busy)
//   i_op         00 MUL, 01 MLA, 10 UMULL, 11 SMULL
//   i_a, i_b     multiplicand (Rm) and multiplier (Rs)
//   i_acc        accumulate operand (Rn), MLA only
//   o_busy       high during the WIDTH iteration cycles
//   o_done       one-cycle pulse when results update
//   o_result_lo  low half of the result
//   o_result_hi  high half of the result (zero for MUL/MLA)
//   o_flags      {N,Z} of the result
module arm_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi,
  output logic [1:0]       o_flags
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] OP_MLA = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0] r_prod;
  logic [1:0]         r_op;
  logic               r_neg;
  logic               w_accept;
  logic               w_last;
  logic               w_long;
  logic               w_smull_in;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_shift;
  logic [2*WIDTH-1:0] w_full;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic [1:0]         w_flags;
  assign w_accept   = i_start && (r_state != RUN);
  assign w_last     = (r_state == RUN) && (r_cnt == LAST);
  assign w_long     = r_op[1];
  assign w_smull_in = (i_op == OP_SMULL);
  // SMULL runs on magnitudes; the most negative value negates to itself,
  // which read as unsigned is exactly the wanted magnitude 2^(W-1).
  assign w_a_mag = (w_smull_in && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag = (w_smull_in && i_b[WIDTH-1]) ? -i_b : i_b;
  // Multiplier sits in the low half of r_prod and is consumed LSB first;
  // the carry of the upper-half add shifts in at the top.
  assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_shift = {w_sum, r_prod[WIDTH-1:1]};
  assign w_full  = (r_op == OP_SMULL && r_neg) ? -w_shift : w_shift;
  assign w_lo    = w_long ? w_full[WIDTH-1:0] : w_shift[WIDTH-1:0] + ((r_op == OP_MLA) ? r_acc : '0);
  assign w_hi    = w_long ? w_full[2*WIDTH-1:WIDTH] : '0;
  assign w_flags = {w_long ? w_hi[WIDTH-1] : w_lo[WIDTH-1], ~|{w_hi, w_lo}};
  assign o_busy  = (r_state == RUN);
  assign o_done  = (r_state == DONE);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  always_comb begin
    w_next = w_accept ? RUN : (r_state == DONE) ? IDLE : w_last ? DONE : r_state;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_op        <= '0;
      r_neg       <= 1'b0;
      o_result_lo <= '0;
      o_result_hi <= '0;
      o_flags     <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_a    <= w_a_mag;
      r_acc  <= i_acc;
      r_prod <= {{WIDTH{1'b0}}, w_b_mag};
      r_op   <= i_op;
      r_neg  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
    end else if (r_state == RUN) begin
      r_cnt  <= r_cnt + 1'b1;
      r_prod <= w_shift;
      if (w_last) begin
        o_result_lo <= w_lo;
        o_result_hi <= w_hi;
        o_flags     <= w_flags;
      end
    end
  end
endmodule

// File: tb/tb_arm_mul_unit.sv
// tb_arm_mul_unit: directed table, random model comparison and control-sequence checks for arm_mul_unit.
module tb_arm_mul_unit;
  localparam int W = 32;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0, acc = '0;
  logic          busy, done;
  logic [W-1:0]  res_lo, res_hi;
  logic [1:0]    flags;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  arm_mul_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_op(op),
    .i_a(a), .i_b(b), .i_acc(acc), .o_busy(busy), .o_done(done),
    .o_result_lo(res_lo), .o_result_hi(res_hi), .o_flags(flags)
  );
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, acc;
    logic [W-1:0] lo, hi;
    logic [1:0]   fl;
  } vec_t;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference: plain wide arithmetic on the operation definitions.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] z, output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic [1:0] fl);
    logic [63:0] p;
    logic signed [63:0] sx, sy;
    sx = {{32{x[W-1]}}, x};
    sy = {{32{y[W-1]}}, y};
    case (o)
      2'b00: p = {32'h0, x * y};
      2'b01: p = {32'h0, x * y + z};
      2'b10: p = {32'h0, x} * {32'h0, y};
      default: p = sx * sy;
    endcase
    lo = p[31:0];
    hi = p[63:32];
    fl = {o[1] ? hi[W-1] : lo[W-1], p == 64'h0};
  endtask
  // Waits for done after an acceptance edge; returns edges counted and whether busy misbehaved.
  task automatic wait_done(output int edges, output bit bad);
    edges = 0;
    bad = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (busy && done) bad = 1;
      if (!done && !busy) bad = 1;
    end while (!done && edges < 40);
  endtask
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    op = o; a = x; b = y; acc = z; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom; acc = $urandom;
  endtask
  task automatic run_check(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] z);
    logic [W-1:0] elo, ehi;
    logic [1:0] efl;
    int edges;
    bit bad;
    model(o, x, y, z, elo, ehi, efl);
    launch(o, x, y, z);
    wait_done(edges, bad);
    check({tag, " latency"}, 64'(edges), 64'd32);
    check({tag, " busy"}, 64'(bad), 64'd0);
    check({tag, " lo"}, 64'(res_lo), 64'(elo));
    check({tag, " hi"}, 64'(res_hi), 64'(ehi));
    check({tag, " flags"}, 64'(flags), 64'(efl));
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t tbl[10];
    logic [W-1:0] elo, ehi;
    logic [1:0] efl;
    int edges;
    bit bad;
    tbl[0] = '{2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 32'd0, 2'b00};
    tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd1, 32'd0, 2'b00};
    tbl[2] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h1, 32'hFFFFFFFE, 2'b10};
    tbl[3] = '{2'b11, 32'hFFFFFFFD, 32'd5, 32'd0, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10};
    tbl[4] = '{2'b11, 32'h80000000, 32'h80000000, 32'd0, 32'h0, 32'h40000000, 2'b00};
    tbl[5] = '{2'b11, 32'd0, 32'h12345678, 32'd0, 32'h0, 32'h0, 2'b01};
    tbl[6] = '{2'b10, 32'h80000000, 32'd2, 32'd0, 32'h0, 32'h1, 2'b00};
    tbl[7] = '{2'b01, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 2'b01};
    tbl[8] = '{2'b00, 32'd3, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFD, 32'h0, 2'b10};
    tbl[9] = '{2'b11, 32'd5, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 2'b10};
    // Reset held with random inputs, then released with start low.
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom; acc = $urandom;
      @(negedge clk);
      check("reset outs", {26'h0, busy, done, flags, 32'h0}, 64'h0);
      check("reset res", {res_hi, res_lo}, 64'h0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle outs", {26'h0, busy, done, flags, 32'h0}, 64'h0);
    check("idle res", {res_hi, res_lo}, 64'h0);
    @(posedge clk);
    #1;
    // Directed table.
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] mlo, mhi;
      logic [1:0] mfl;
      model(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].acc, mlo, mhi, mfl);
      check($sformatf("model%0d", i), {mhi, mlo}, {tbl[i].hi, tbl[i].lo});
      launch(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].acc);
      wait_done(edges, bad);
      check($sformatf("tbl%0d latency", i), 64'(edges), 64'd32);
      check($sformatf("tbl%0d busy", i), 64'(bad), 64'd0);
      check($sformatf("tbl%0d result", i), {res_hi, res_lo}, {tbl[i].hi, tbl[i].lo});
      check($sformatf("tbl%0d flags", i), 64'(flags), 64'(tbl[i].fl));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d done drop", i), {62'h0, busy, done}, 64'h0);
    end
    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = (i % 5 == 0) ? 32'h80000000 : $urandom;
      y = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      run_check($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), x, y, $urandom);
    end
    // Start pulse at RUN cycle 5 must be ignored.
    launch(2'b00, 32'd7, 32'd6, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    op = 2'b10; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(edges, bad);
    check("ignored start latency", 64'(edges + 5), 64'd32);
    check("ignored start result", {res_hi, res_lo}, 64'd42);
    // Back-to-back start sampled in DONE.
    model(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, elo, ehi, efl);
    launch(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    check("b2b accept", {62'h0, busy, done}, 64'h2);
    wait_done(edges, bad);
    check("b2b spacing", 64'(edges + 1), 64'd33);
    check("b2b result", {res_hi, res_lo}, {ehi, elo});
    check("b2b flags", 64'(flags), 64'(efl));
    @(posedge clk);
    #1;
    // Asynchronous reset at RUN cycle 10.
    launch(2'b11, 32'hFFFFFFFD, 32'd5, 32'd0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun reset outs", {26'h0, busy, done, flags, 32'h0}, 64'h0);
    check("midrun reset res", {res_hi, res_lo}, 64'h0);
    repeat (2) @(negedge clk);
    check("reset held no done", {62'h0, busy, done}, 64'h0);
    op = 2'b01; a = 32'd100; b = 32'd100; acc = 32'd5; start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("post reset accept", {62'h0, busy, done}, 64'h2);
    wait_done(edges, bad);
    check("post reset latency", 64'(edges), 64'd32);
    check("post reset result", {res_hi, res_lo}, 64'd10005);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
